// File: rtl/cic_comp_pkg.sv
// Shared definitions for the CIC compensation FIR: default sizing, FSM encoding
// and the symmetric 16-tap droop-compensation coefficient table.
package cic_comp_pkg;

  localparam int unsigned DATA_W        = 8;
  localparam int unsigned TAPS_DEF      = 16;
  localparam int unsigned COEF_W_DEF    = 10;
  localparam int unsigned OUT_SHIFT_DEF = 10;
  localparam int unsigned COEF_IDX_W    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Symmetric table, coefficients sum to 1024 for unity DC gain at a shift of 10.
  localparam logic signed [COEF_W_DEF-1:0] COEF_TABLE [TAPS_DEF] = '{
    -10'sd4,  -10'sd8,  10'sd6,   10'sd20, -10'sd12, -10'sd40, 10'sd60,  10'sd490,
    10'sd490, 10'sd60,  -10'sd40, -10'sd12, 10'sd20,  10'sd6,  -10'sd8,  -10'sd4
  };

  function automatic logic signed [COEF_W_DEF-1:0] coef_at(input logic [COEF_IDX_W-1:0] idx);
    return COEF_TABLE[idx];
  endfunction

endpackage

// File: rtl/cic_comp_mac.sv
// Registered signed multiply-accumulate with synchronous clear and enable.
module cic_comp_mac #(
  parameter int unsigned A_W   = 8,
  parameter int unsigned B_W   = 10,
  parameter int unsigned ACC_W = 22
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [A_W-1:0]   a,
  input  logic signed [B_W-1:0]   b,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [A_W+B_W-1:0] prod_c;

  assign prod_c = a * b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_W'(prod_c);
    end
  end

endmodule

// File: rtl/cic_comp_fir.sv
// CIC droop-compensation FIR: captures one sample per d_clk rising edge, runs a
// serial one-tap-per-clock MAC, then emits a saturated 8-bit result.
module cic_comp_fir
  import cic_comp_pkg::*;
#(
  parameter int unsigned TAPS      = TAPS_DEF,
  parameter int unsigned COEF_W    = COEF_W_DEF,
  parameter int unsigned OUT_SHIFT = OUT_SHIFT_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] d_in,
  input  logic                     d_clk,
  output logic signed [DATA_W-1:0] d_out,
  output logic                     out_valid,
  output logic                     overrun
);

  localparam int unsigned IDX_W = $clog2(TAPS);
  localparam int unsigned ACC_W = DATA_W + COEF_W + IDX_W;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-128);

  state_t                    state;
  logic [IDX_W-1:0]          wr_ptr;
  logic [IDX_W-1:0]          tap;
  logic                      d_clk_prev;
  logic signed [DATA_W-1:0]  sample_buf [TAPS];
  logic signed [ACC_W-1:0]   acc;

  logic                      edge_c;
  logic                      mac_clr_c;
  logic                      mac_en_c;
  logic [IDX_W-1:0]          rd_idx_c;
  logic signed [COEF_W-1:0]  coef_c;
  logic signed [ACC_W-1:0]   shifted_c;
  logic signed [DATA_W-1:0]  sat_c;

  assign edge_c    = d_clk & ~d_clk_prev;
  assign mac_clr_c = (state == IDLE) && edge_c;
  assign mac_en_c  = (state == MAC);
  // Tap i reads x[n-i]; modulo TAPS falls out of the IDX_W-bit wrap.
  assign rd_idx_c  = wr_ptr - tap;
  assign coef_c    = COEF_W'(coef_at(COEF_IDX_W'(tap)));
  assign shifted_c = acc >>> OUT_SHIFT;

  always_comb begin
    sat_c = shifted_c[DATA_W-1:0];
    if (shifted_c > SAT_MAX) begin
      sat_c = 8'sd127;
    end else if (shifted_c < SAT_MIN) begin
      sat_c = -8'sd128;
    end
  end

  cic_comp_mac #(
    .A_W   (DATA_W),
    .B_W   (COEF_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (mac_clr_c),
    .en  (mac_en_c),
    .a   (sample_buf[rd_idx_c]),
    .b   (coef_c),
    .acc (acc)
  );

  // d_clk_prev resets high so a strobe already high at release is not an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      d_out      <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
      wr_ptr     <= '0;
      tap        <= '0;
      d_clk_prev <= 1'b1;
      for (int i = 0; i < int'(TAPS); i++) begin
        sample_buf[i] <= '0;
      end
    end else begin
      d_clk_prev <= d_clk;
      out_valid  <= 1'b0;
      if (edge_c && (state != IDLE)) begin
        overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (edge_c) begin
            sample_buf[wr_ptr] <= d_in;
            tap                <= '0;
            state              <= MAC;
          end
        end
        MAC: begin
          tap <= tap + 1'b1;
          if (tap == IDX_W'(TAPS - 1)) begin
            state <= OUT;
          end
        end
        OUT: begin
          d_out     <= sat_c;
          out_valid <= 1'b1;
          wr_ptr    <= wr_ptr + 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cic_comp_fir.sv
// Scoreboard bench for cic_comp_fir: two instances (shift 10 and 8) share the
// stimulus; a reference FIR over the accepted-sample history predicts both.
module tb_cic_comp_fir;

  logic              clk = 1'b0;
  logic              rst;
  logic              d_clk;
  logic signed [7:0] d_in;
  logic signed [7:0] d_out_a, d_out_b;
  logic              vld_a, vld_b, ovr_a, ovr_b;

  always #5 clk = ~clk;

  cic_comp_fir u_dut_a (
    .clk(clk), .rst(rst), .d_in(d_in), .d_clk(d_clk),
    .d_out(d_out_a), .out_valid(vld_a), .overrun(ovr_a)
  );

  cic_comp_fir #(.OUT_SHIFT(8)) u_dut_b (
    .clk(clk), .rst(rst), .d_in(d_in), .d_clk(d_clk),
    .d_out(d_out_b), .out_valid(vld_b), .overrun(ovr_b)
  );

  typedef struct {
    int val;
    int cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   hist[$];
  int   coef_tab[16] = '{-4, -8, 6, 20, -12, -40, 60, 490,
                         490, 60, -40, -12, 20, 6, -8, -4};
  int   cyc = 0;
  int   next_ok = 0;
  bit   ovr_exp = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // y[n] = sat8(floor(sum c[i]*x[n-i] / 2^s)), history before reset is zero.
  function automatic int model(input int s);
    int sum = 0;
    int v;
    for (int i = 0; i < 16; i++) begin
      if (i < hist.size()) sum += coef_tab[i] * hist[i];
    end
    v = sum >>> s;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return v;
  endfunction

  // Scoreboard monitor: every out_valid must match the oldest expectation in value and cycle.
  always @(negedge clk) begin
    exp_t e;
    if (vld_a) begin
      if (q_a.size() == 0) chk("unexpected out_valid A", 1, 0);
      else begin
        e = q_a.pop_front();
        chk("d_out A", int'(d_out_a), e.val);
        chk("latency A", cyc, e.cyc);
      end
    end
    if (vld_b) begin
      if (q_b.size() == 0) chk("unexpected out_valid B", 1, 0);
      else begin
        e = q_b.pop_front();
        chk("d_out B", int'(d_out_b), e.val);
        chk("latency B", cyc, e.cyc);
      end
    end
  end

  // Called at a negedge; the edge is detected at the following posedge.
  task automatic send(input int v, input int gap);
    int det;
    exp_t e;
    det   = cyc + 1;
    d_in  = 8'(v);
    d_clk = 1'b1;
    if (det >= next_ok) begin
      hist.push_front(v);
      if (hist.size() > 16) void'(hist.pop_back());
      e.cyc = det + 17;
      e.val = model(10);
      q_a.push_back(e);
      e.val = model(8);
      q_b.push_back(e);
      next_ok = det + 18;
    end else begin
      ovr_exp = 1'b1;
    end
    @(negedge clk);
    d_clk = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic do_reset(input bit dclk_level);
    @(negedge clk);
    rst   = 1'b1;
    d_clk = dclk_level;
    q_a.delete();
    q_b.delete();
    hist.delete();
    next_ok = 0;
    ovr_exp = 1'b0;
    #1;
    chk("reset d_out A", int'(d_out_a), 0);
    chk("reset d_out B", int'(d_out_b), 0);
    chk("reset out_valid", int'(vld_a | vld_b), 0);
    chk("reset overrun", int'(ovr_a | ovr_b), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_ovr(input string name);
    chk({name, " A"}, int'(ovr_a), int'(ovr_exp));
    chk({name, " B"}, int'(ovr_b), int'(ovr_exp));
  endtask

  initial begin
    rst   = 1'b1;
    d_clk = 1'b0;
    d_in  = '0;
    do_reset(1'b0);

    // Impulse response at the relaxed 40-clock spacing
    send(64, 40);
    repeat (19) send(0, 40);

    // DC levels at the minimum lossless spacing
    repeat (20) send(100, 18);
    repeat (20) send(-128, 18);
    repeat (20) send(-100, 18);
    chk_ovr("overrun after lossless");

    // Second edge 5 clocks after the first is dropped
    send(5, 5);
    send(77, 40);
    chk_ovr("overrun set");
    repeat (18) send(0, 18);
    chk_ovr("overrun held");

    // Random samples with occasional too-close edges
    for (int k = 0; k < 50; k++) begin
      int v, g;
      v = int'($urandom_range(0, 255)) - 128;
      g = ($urandom_range(0, 9) == 0) ? int'($urandom_range(2, 17)) : int'($urandom_range(18, 24));
      send(v, g);
    end
    chk_ovr("overrun after random");

    // Reset mid-MAC with d_clk held high across release
    send(50, 6);
    do_reset(1'b1);
    repeat (30) @(negedge clk);
    chk("no output after release A", int'(d_out_a), 0);
    chk("no output after release B", int'(d_out_b), 0);
    chk_ovr("overrun after release");
    d_clk = 1'b0;
    repeat (3) @(negedge clk);

    // Edge landing on the OUT clock is an overrun
    send(10, 17);
    chk_ovr("overrun before OUT-edge");
    send(20, 18);
    chk_ovr("overrun on OUT-edge");

    // Ramp across several write-pointer wraps
    for (int k = 0; k < 40; k++) send(k, 18);

    repeat (40) @(negedge clk);
    chk("pending outputs A", q_a.size(), 0);
    chk("pending outputs B", q_b.size(), 0);
    chk_ovr("final overrun");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
